// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard event receiver: prefix codes,
// frame FSM states and the queued event record.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } frame_state_e;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } ps2_event_t;

    localparam int EVENT_W = $bits(ps2_event_t);

    // Frame layout (LSB first on the wire): [0]=start, [8:1]=data, [9]=parity, [10]=stop.
    function automatic logic frame_ok(input logic [10:0] f);
        return (f[0] == 1'b0) && f[10] && (^f[9:1]);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read; a push into a full FIFO
// succeeds only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers are exactly AW bits wide so the increment wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_event_rx.sv
// PS/2 keyboard receiver: synchronises the device lines, assembles 11-bit
// frames, folds E0/F0 prefixes into flags and queues key events.
module ps2_kbd_event_rx
    import ps2_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int DECODE         = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    output logic                     ev_valid,
    output logic [7:0]               ev_code,
    output logic                     ev_break,
    output logic                     ev_ext,
    input  logic                     ev_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic                     err_pulse
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]   clk_sync_q;
    logic [2:0]   data_sync_q;
    logic         ps2_fall;
    logic         data_bit;

    frame_state_e state_q, state_d;
    logic [3:0]   bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [10:0]  frame_q, frame_d;
    logic         ext_q, ext_d;
    logic         brk_q, brk_d;
    logic         overflow_q, overflow_d;

    logic         push;
    ps2_event_t   push_ev;
    ps2_event_t   head_ev;
    logic         fifo_full;
    logic         fifo_empty;
    logic         pop;
    logic         drop;

    // Reset to all-ones so an idle (high) bus never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 3'b111;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
            data_sync_q <= {data_sync_q[1:0], ps2_data};
        end
    end

    assign ps2_fall = clk_sync_q[2] & ~clk_sync_q[1];
    assign data_bit = data_sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            tmo_q      <= '0;
            frame_q    <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tmo_q      <= tmo_d;
            frame_q    <= frame_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tmo_d     = tmo_q;
        frame_d   = frame_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        err_pulse = 1'b0;
        push      = 1'b0;
        push_ev   = '0;

        unique case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (ps2_fall) begin
                    frame_d   = {data_bit, frame_q[10:1]};
                    bit_cnt_d = 4'd1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ps2_fall) begin
                    frame_d = {data_bit, frame_q[10:1]};
                    tmo_d   = '0;
                    if (bit_cnt_q == 4'd10) begin
                        bit_cnt_d = '0;
                        state_d   = ST_CHECK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // A stalled frame counts as rejected, so pending prefixes go too.
                    bit_cnt_d = '0;
                    tmo_d     = '0;
                    state_d   = ST_IDLE;
                    err_pulse = 1'b1;
                    ext_d     = 1'b0;
                    brk_d     = 1'b0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (!frame_ok(frame_q)) begin
                    err_pulse = 1'b1;
                    ext_d     = 1'b0;
                    brk_d     = 1'b0;
                end else if ((DECODE != 0) && (frame_q[8:1] == PS2_EXT)) begin
                    ext_d = 1'b1;
                end else if ((DECODE != 0) && (frame_q[8:1] == PS2_BRK)) begin
                    brk_d = 1'b1;
                end else begin
                    push         = 1'b1;
                    push_ev.code = frame_q[8:1];
                    push_ev.brk  = brk_q;
                    push_ev.ext  = ext_q;
                    ext_d        = 1'b0;
                    brk_d        = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ev_valid = !fifo_empty;
    assign pop      = ev_valid && ev_ready;
    assign drop     = push && fifo_full && !pop;

    // A drop in the same cycle as a clear wins, so no loss goes unreported.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    assign overflow = overflow_q;

    sync_fifo #(
        .WIDTH (EVENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_ev),
        .pop   (pop),
        .dout  (head_ev),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign ev_code  = head_ev.code;
    assign ev_break = head_ev.brk;
    assign ev_ext   = head_ev.ext;

endmodule

// File: doc/ps2_kbd_event_rx.md
PS2_KBD_EVENT_RX -- requirements
Module: ps2_kbd_event_rx

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning event FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 5000, meaning clk cycles without a ps2_clk falling edge before a partial frame is aborted.
REQ-003 SHALL have parameter DECODE, default 1, meaning 1 = consume E0/F0 prefixes into flags, 0 = raw mode with every byte queued and flags 0.
REQ-004 SHALL have port clk  in  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports ps2_clk and ps2_data  in  1  asynchronous PS/2 device lines.
REQ-007 SHALL have port ev_valid  out  1  FIFO non-empty.
REQ-008 SHALL have ports ev_code out 8, ev_break out 1, ev_ext out 1: head-of-FIFO scan code, release flag, E0-extended flag.
REQ-009 SHALL have port ev_ready  in  1  consumer pop; pop occurs when ev_valid && ev_ready.
REQ-010 SHALL have port count  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-011 SHALL have port overflow  out  1  sticky; an event was dropped because the FIFO was full.
REQ-012 SHALL have port ovf_clr  in  1  clears overflow.
REQ-013 SHALL have port err_pulse  out  1  one-cycle pulse per rejected frame (parity, start, stop or timeout).

Function
REQ-014 SHALL synchronise ps2_clk and ps2_data through 3 flops each and detect a ps2_clk falling edge from the last two ps2_clk stages.
REQ-015 SHALL sample ps2_data on each detected falling edge into an 11-bit frame: start, 8 data LSB-first, parity, stop.
REQ-016 Frame FSM SHALL use states IDLE (bit counter 0), SHIFT (counter 1..10), CHECK (one cycle after the 11th bit), then return to IDLE.
REQ-017 A frame SHALL be accepted only if start=0, stop=1 and XOR of 8 data bits and parity equals 1 (odd parity); otherwise err_pulse=1 in CHECK and the byte is discarded.
REQ-018 In SHIFT, if TIMEOUT_CYCLES cycles elapse without a falling edge, the FSM SHALL return to IDLE, clear the bit counter and pulse err_pulse.
REQ-019 Decoder (DECODE=1) SHALL hold flags ext and brk: byte E0 sets ext, F0 sets brk, and neither is queued; any other byte pushes {code, brk, ext} and clears both flags.
REQ-020 A rejected frame SHALL clear ext and brk.
REQ-021 Accepted-byte-to-ev_valid latency SHALL be 1 cycle after CHECK when the FIFO was empty.
REQ-022 ev_code, ev_break and ev_ext SHALL show the head entry combinationally from FIFO storage and remain stable while ev_valid && !ev_ready.
REQ-023 Push when full without a pop in the same cycle SHALL drop the new event and set overflow; existing entries are preserved.
REQ-024 Push and pop in the same cycle when full SHALL both succeed: count is unchanged and overflow is not set.
REQ-025 Push and pop in the same cycle when empty SHALL be impossible, because pop requires ev_valid.
REQ-026 Read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-027 ovf_clr SHALL clear overflow next cycle; if ovf_clr and a drop coincide, overflow SHALL be 1.

Reset
REQ-028 rst SHALL force: frame FSM to IDLE, bit counter 0, timeout counter 0, ext=brk=0, pointers 0, count=0, ev_valid=0, overflow=0, err_pulse=0, and synchroniser flops to 1 (idle bus).
REQ-029 rst asserted mid-frame SHALL discard the partial frame with no err_pulse; the next frame after rst deasserts SHALL be received normally.

Structure
REQ-030 A shared package ps2_pkg SHALL hold constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, the frame FSM state enum, and the event struct {brk, ext, code[7:0]}.
REQ-031 The FIFO SHALL be one sub-module, sync_fifo (params WIDTH, DEPTH), with push/pop/full/empty/count ports.

Verification
REQ-032 Send 1C, then hold ev_ready=0 -> one event {1C, brk 0, ext 0}, count=1, stable until popped.
REQ-033 Send F0,1C then E0,F0,75 -> two events {1C,1,0} and {75,1,1}; no event is produced for the prefixes.
REQ-034 Send 1C with even parity -> err_pulse exactly 1 cycle, count stays 0; next valid 1B is queued as {1B,0,0}.
REQ-035 DEPTH=4: send 5 codes 10..14 with no pop -> count=4, overflow=1, pops yield 10,11,12,13; ovf_clr -> overflow=0.
REQ-036 With the FIFO full, pop on the same cycle as a push -> count stays 4, overflow stays 0, order preserved.
REQ-037 Stop ps2_clk after 5 bits for TIMEOUT_CYCLES -> err_pulse; then full frame 1C -> event {1C,0,0}; assert rst mid-frame -> all outputs at reset values, no err_pulse.
